// File: rtl/pkg_cronometro.sv
// Shared definitions for the stopwatch lap-time path: state encoding of the
// recall controller and default geometry of the lap-time store.
package pkg_cronometro;

  localparam int unsigned DEF_NUM_ENTRIES = 4;
  localparam int unsigned DEF_ADDR_WIDTH  = 2;
  localparam int unsigned DEF_DATA_WIDTH  = 16;

  localparam logic [1:0] ESTADO_LIVE   = 2'd0;
  localparam logic [1:0] ESTADO_RECALL = 2'd1;
  localparam logic [1:0] ESTADO_SCAN   = 2'd2;

  typedef enum logic [1:0] {
    StLive   = ESTADO_LIVE,
    StRecall = ESTADO_RECALL,
    StScan   = ESTADO_SCAN
  } estado_e;

endpackage

// File: rtl/temporizador_varredura.sv
// Auto-scan dwell timer. While enabled it counts clock cycles and emits a
// one-cycle tick on the last cycle of each SCAN_TICKS-cycle dwell.
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   enable_i  : count while high; counter held at 0 while low
//   restart_i : force the counter back to 0 (start a fresh dwell)
//   tick_o    : high on the final cycle of a dwell
module temporizador_varredura #(
  parameter int unsigned SCAN_TICKS = 50000000,
  parameter int unsigned CNT_WIDTH  = 26
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam logic [CNT_WIDTH-1:0] LastCount = CNT_WIDTH'(SCAN_TICKS - 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 at_last;

  assign at_last = (cnt_q == LastCount);

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick_o = 1'b0;
    if (restart_i || !enable_i) begin
      cnt_d = '0;
    end else if (at_last) begin
      cnt_d  = '0;
      tick_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/leitor_memoria.sv
// Read-side controller of the 4-entry lap-time store. Lets the user leave the
// live display and step through stored laps manually or by timed auto-scan.
//   clock, reset_n          : clock, asynchronous active-low reset
//   write_enable            : store write pulse (writer fills 0,1,2,3 in order)
//   clear                   : invalidate all laps
//   recall_button           : enter recall / advance one entry
//   scan_toggle             : toggle auto-scan while recalling
//   exit_button             : back to live display
//   live_time               : running stopwatch value (BCD)
//   mem_data                : store data_out, combinational from read_address
//   read_address            : registered read index
//   display_data            : registered BCD word for the display
//   showing_recall/scanning : decoded from the registered state
//   entries_stored          : number of valid laps, 0..NUM_ENTRIES
module leitor_memoria
  import pkg_cronometro::*;
#(
  parameter int unsigned NUM_ENTRIES = pkg_cronometro::DEF_NUM_ENTRIES,
  parameter int unsigned ADDR_WIDTH  = pkg_cronometro::DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = pkg_cronometro::DEF_DATA_WIDTH,
  parameter int unsigned SCAN_TICKS  = 50000000,
  parameter int unsigned CNT_WIDTH   = 26
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  write_enable,
  input  logic                  clear,
  input  logic                  recall_button,
  input  logic                  scan_toggle,
  input  logic                  exit_button,
  input  logic [DATA_WIDTH-1:0] live_time,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0] display_data,
  output logic                  showing_recall,
  output logic                  scanning,
  output logic [ADDR_WIDTH:0]   entries_stored
);

  localparam logic [ADDR_WIDTH:0] MaxCount = (ADDR_WIDTH + 1)'(NUM_ENTRIES);

  estado_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] disp_q, disp_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   addr_inc;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  scan_restart;
  logic                  scan_tick;

  // Wrap at the number of valid entries, not at the store depth.
  assign addr_inc  = {1'b0, addr_q} + 1'b1;
  assign addr_next = (addr_inc >= count_q) ? '0 : addr_inc[ADDR_WIDTH-1:0];

  temporizador_varredura #(
    .SCAN_TICKS (SCAN_TICKS),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_temporizador (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .enable_i  (state_q == StScan),
    .restart_i (scan_restart),
    .tick_o    (scan_tick)
  );

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (write_enable && (count_q < MaxCount)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Priority: clear > exit > scan_toggle > recall; lower pulses are dropped.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    scan_restart = 1'b0;
    if (clear) begin
      state_d      = StLive;
      addr_d       = '0;
      scan_restart = 1'b1;
    end else begin
      unique case (state_q)
        StLive: begin
          addr_d = '0;
          if (!exit_button && !scan_toggle && recall_button && (count_q != '0)) begin
            state_d = StRecall;
          end
        end
        StRecall: begin
          if (exit_button) begin
            state_d = StLive;
            addr_d  = '0;
          end else if (scan_toggle) begin
            state_d = StScan;
          end else if (recall_button) begin
            addr_d = addr_next;
          end
        end
        StScan: begin
          if (exit_button) begin
            state_d = StLive;
            addr_d  = '0;
          end else if (scan_toggle) begin
            state_d = StRecall;
          end else if (recall_button) begin
            addr_d       = addr_next;
            scan_restart = 1'b1;
          end else if (scan_tick) begin
            addr_d = addr_next;
          end
        end
        default: begin
          state_d = StLive;
          addr_d  = '0;
        end
      endcase
    end
  end

  assign disp_d = (state_q == StLive) ? live_time : mem_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StLive;
      addr_q  <= '0;
      disp_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      disp_q  <= disp_d;
      count_q <= count_d;
    end
  end

  assign read_address   = addr_q;
  assign display_data   = disp_q;
  assign showing_recall = (state_q != StLive);
  assign scanning       = (state_q == StScan);
  assign entries_stored = count_q;

endmodule

// File: tb/tb_leitor_memoria.sv
module tb_leitor_memoria;

  localparam int Ticks = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        write_enable, clear, recall_button, scan_toggle, exit_button;
  logic [15:0] live_time, mem_data;
  logic [1:0]  read_address;
  logic [15:0] display_data;
  logic        showing_recall, scanning;
  logic [2:0]  entries_stored;

  // Behavioural lap-time store written in order 0,1,2,3.
  logic [15:0] store [4];
  int          wptr;
  logic [15:0] wdata;

  assign mem_data = store[read_address];

  always #5 clock = ~clock;

  leitor_memoria #(
    .NUM_ENTRIES (4),
    .ADDR_WIDTH  (2),
    .DATA_WIDTH  (16),
    .SCAN_TICKS  (Ticks),
    .CNT_WIDTH   (3)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .write_enable   (write_enable),
    .clear          (clear),
    .recall_button  (recall_button),
    .scan_toggle    (scan_toggle),
    .exit_button    (exit_button),
    .live_time      (live_time),
    .mem_data       (mem_data),
    .read_address   (read_address),
    .display_data   (display_data),
    .showing_recall (showing_recall),
    .scanning       (scanning),
    .entries_stored (entries_stored)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: viewing live or a stored lap, optionally auto-scanning.
  bit          m_viewing;
  bit          m_auto;
  int          m_idx;
  int          m_count;
  int          m_dwell;
  logic [15:0] m_disp;

  function automatic int wrap_next(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

  task automatic model_reset();
    m_viewing = 0; m_auto = 0; m_idx = 0; m_count = 0; m_dwell = 0; m_disp = '0;
  endtask

  // Evaluated with the pre-edge inputs and pre-edge store contents.
  task automatic model_step();
    int old_count;
    old_count = m_count;
    m_disp = m_viewing ? store[m_idx] : live_time;
    if (clear) m_count = 0;
    else if (write_enable && m_count < 4) m_count++;
    if (clear) begin
      m_viewing = 0; m_auto = 0; m_idx = 0; m_dwell = 0;
    end else if (!m_viewing) begin
      if (!exit_button && !scan_toggle && recall_button && old_count > 0) begin
        m_viewing = 1; m_idx = 0;
      end
    end else if (exit_button) begin
      m_viewing = 0; m_auto = 0; m_idx = 0;
    end else if (scan_toggle) begin
      m_auto = !m_auto; m_dwell = 0;
    end else if (recall_button) begin
      m_idx = wrap_next(m_idx, old_count); m_dwell = 0;
    end else if (m_auto) begin
      m_dwell++;
      if (m_dwell == Ticks) begin
        m_idx = wrap_next(m_idx, old_count); m_dwell = 0;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("read_address", 32'(read_address), 32'(m_idx));
    check_eq("display_data", 32'(display_data), 32'(m_disp));
    check_eq("showing_recall", 32'(showing_recall), 32'(m_viewing));
    check_eq("scanning", 32'(scanning), 32'(m_auto));
    check_eq("entries_stored", 32'(entries_stored), 32'(m_count));
  endtask

  // One clock cycle with the given pulses; inputs are dropped afterwards.
  task automatic step(input bit cl, input bit we, input bit rb, input bit st, input bit ex);
    clear = cl; write_enable = we; recall_button = rb; scan_toggle = st; exit_button = ex;
    live_time = 16'($urandom);
    wdata = 16'($urandom);
    model_step();
    @(posedge clock);
    #1;
    if (cl) wptr = 0;
    else if (we) begin
      store[wptr] = wdata;
      wptr = (wptr + 1) % 4;
    end
    clear = 0; write_enable = 0; recall_button = 0; scan_toggle = 0; exit_button = 0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) store[i] = 16'h0;
    wptr = 0; wdata = '0;
    clear = 0; write_enable = 0; recall_button = 0; scan_toggle = 0; exit_button = 0;
    live_time = 16'h1234;
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    compare_all();
    @(negedge clock);
    reset_n = 1;

    // Three laps, then recall: wraps at 3 entries.
    repeat (3) step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle(1);
    repeat (3) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);

    // Four laps, auto-scan with a manual advance mid-dwell.
    step(1, 0, 0, 0, 0);
    repeat (4) step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(10);
    step(0, 0, 1, 0, 0);
    idle(9);
    // clear beats a simultaneous write while scanning.
    step(1, 1, 0, 0, 0);
    // Empty store: recall ignored, live view follows live_time.
    step(0, 0, 1, 0, 0);
    idle(2);
    // Saturation at 4 entries.
    repeat (5) step(0, 1, 0, 0, 0);
    // Priority: exit drops recall in the same cycle.
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 29) == 0));
    end

    // Asynchronous reset mid-scan, away from any clock edge.
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(2);
    check_eq("pre_reset_scanning", 32'(scanning), 32'd1);
    #2;
    reset_n = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge clock);
    reset_n = 1;
    for (int i = 0; i < 4; i++) store[i] = 16'h0;
    wptr = 0;
    idle(2);
    repeat (2) step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
